// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants, legal oversampling
// ratios and the parity-type encoding (common to uart_rx and uart_tx).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int DATA_BITS = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything other than 16 or 32 collapses to 8 so the counters always
  // see a ratio they were sized for.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

  // Even: XOR of the data. Odd: XNOR of the data.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic typ);
    return (typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling front end: edge counter within a bit, bit counter within a
// frame, and a 3-point majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       active,
  input  logic       in_frame,
  input  logic       rx,
  input  logic [5:0] prescale,
  output logic       bit_done,
  output logic       bit_val,
  output logic [3:0] bit_cnt
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [2:0] samples;
  logic       last_edge;

  assign half      = {1'b0, prescale[5:1]};
  assign last_edge = (edge_cnt == (prescale - 6'd1));
  assign bit_done  = in_frame && last_edge;
  assign bit_val   = (samples[0] & samples[1]) |
                     (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

  // Edge counter: the start-detect cycle is edge 0, so it counts whenever
  // a frame is in progress or is starting this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt <= 6'd0;
    end else if (!active || last_edge) begin
      edge_cnt <= 6'd0;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Bit counter is forced to 0 in IDLE so a back-to-back start begins clean.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= 4'd0;
    end else if (!in_frame) begin
      bit_cnt <= 4'd0;
    end else if (last_edge) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Capture the three samples around the bit centre; all are rewritten
  // every bit before the vote is consumed at the last edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samples <= 3'b111;
    end else if (active) begin
      if (edge_cnt == (half - 6'd1)) samples[0] <= rx;
      if (edge_cnt == half)          samples[1] <= rx;
      if (edge_cnt == (half + 6'd1)) samples[2] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, frame FSM, deserializer, parity and stop
// checks, and the registered result pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low
// START  | start bit; a sampled 1 is a glitch and aborts
// DATA   | 8 data bits, LSB first, shifted in
// PARITY | optional parity bit, compared to computed parity
// STOP   | stop bit; result pulses issued when it ends
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  state_e state, state_nxt;

  logic [5:0]           presc_q;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_fail;

  logic       start_det;
  logic       in_frame;
  logic       bit_done;
  logic       bit_val;
  logic [3:0] bit_cnt;
  logic       shift_en;
  logic       par_chk;
  logic       stop_chk;

  assign start_det = (state == IDLE) && !RX_IN;
  assign in_frame  = (state != IDLE);

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .rstn     (rstn),
    .active   (in_frame || start_det),
    .in_frame (in_frame),
    .rx       (RX_IN),
    .prescale (presc_q),
    .bit_done (bit_done),
    .bit_val  (bit_val),
    .bit_cnt  (bit_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-bit strobes for the datapath.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        if (bit_done) state_nxt = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(DATA_BITS)) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          stop_chk  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame configuration is frozen at start detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q   <= PRESCALE_8;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (start_det) begin
      presc_q   <= norm_prescale(prescale);
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  // Deserializer: first received bit ends up in bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Parity result is held until the stop bit reports it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_fail <= 1'b0;
    end else if (start_det) begin
      par_fail <= 1'b0;
    end else if (par_chk) begin
      par_fail <= (bit_val != calc_parity(shift_reg, par_typ_q));
    end
  end

  // Result pulses and output byte, registered on the stop-bit's last edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      P_DATA     <= 8'h00;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (stop_chk) begin
        par_err <= par_fail;
        stp_err <= !bit_val;
        if (!par_fail && bit_val) begin
          data_valid <= 1'b1;
          P_DATA     <= shift_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk;
  logic       rstn;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int t0  = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc = 0, dv_cyc_prev = 0, pe_cyc = 0, se_cyc = 0;
  logic [7:0] dv_data = 8'h00, dv_data_prev = 8'h00;

  uart_rx dut (
    .clk        (clk),
    .rstn       (rstn),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt       = dv_cnt + 1;
      dv_cyc_prev  = dv_cyc;
      dv_cyc       = cyc;
      dv_data_prev = dv_data;
      dv_data      = P_DATA;
    end
    if (par_err) begin
      pe_cnt = pe_cnt + 1;
      pe_cyc = cyc;
    end
    if (stp_err) begin
      se_cnt = se_cnt + 1;
      se_cyc = cyc;
    end
  end

  // Called at posedge+1; drives one full frame, each bit held p cycles.
  task automatic send_frame(input logic [7:0] data, input bit with_par,
                            input logic par_bit, input logic stop_bit,
                            input int p);
    t0 = cyc;
    RX_IN = 1'b0;
    repeat (p) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      repeat (p) @(posedge clk);
      #1;
    end
    if (with_par) begin
      RX_IN = par_bit;
      repeat (p) @(posedge clk);
      #1;
    end
    RX_IN = stop_bit;
    repeat (p) @(posedge clk);
    #1;
    RX_IN = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_checks++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_pdata got %h exp 00", P_DATA); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b exp 0", data_valid); end
    n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe got %b exp 0", par_err); end
    n_checks++; if (stp_err !== 1'b0) begin n_fail++; $display("FAIL reset_se got %b exp 0", stp_err); end
  endtask

  task automatic test_even_parity;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'b1001_1100, 1'b1, 1'b0, 1'b1, 8);
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL even_dv_count got %0d exp 1", dv_cnt - dv0); end
    n_checks++; if (dv_cyc - t0 !== 88) begin n_fail++; $display("FAIL even_timing got %0d exp 88", dv_cyc - t0); end
    n_checks++; if (P_DATA !== 8'h9C) begin n_fail++; $display("FAIL even_pdata got %h exp 9c", P_DATA); end
    n_checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin n_fail++; $display("FAIL even_errors got %0d exp 0", (pe_cnt - pe0) + (se_cnt - se0)); end
  endtask

  task automatic test_odd_parity;
    int dv0, pe0;
    dv0 = dv_cnt; pe0 = pe_cnt;
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    P_DATA_dummy_wait();
    send_frame(8'b1001_1100, 1'b1, 1'b1, 1'b1, 16);
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL odd_dv_count got %0d exp 1", dv_cnt - dv0); end
    n_checks++; if (dv_cyc - t0 !== 176) begin n_fail++; $display("FAIL odd_timing got %0d exp 176", dv_cyc - t0); end
    n_checks++; if (dv_data !== 8'h9C) begin n_fail++; $display("FAIL odd_pdata got %h exp 9c", dv_data); end
    n_checks++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL odd_pe got %0d exp 0", pe_cnt - pe0); end
  endtask

  task automatic P_DATA_dummy_wait;
    idle(2);
  endtask

  // Config is changed right after start; the frame must still use 32/no parity.
  task automatic test_no_parity;
    int dv0, pe0;
    dv0 = dv_cnt; pe0 = pe_cnt;
    prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 32);
      begin
        idle(3);
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
      end
    join
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL nopar_dv_count got %0d exp 1", dv_cnt - dv0); end
    n_checks++; if (dv_cyc - t0 !== 320) begin n_fail++; $display("FAIL nopar_timing got %0d exp 320", dv_cyc - t0); end
    n_checks++; if (P_DATA !== 8'hC3) begin n_fail++; $display("FAIL nopar_pdata got %h exp c3", P_DATA); end
    n_checks++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL nopar_pe got %0d exp 0", pe_cnt - pe0); end
  endtask

  task automatic test_parity_error;
    int dv0, pe0;
    dv0 = dv_cnt; pe0 = pe_cnt;
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 8);
    idle(4);
    n_checks++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL perr_count got %0d exp 1", pe_cnt - pe0); end
    n_checks++; if (pe_cyc - t0 !== 88) begin n_fail++; $display("FAIL perr_timing got %0d exp 88", pe_cyc - t0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL perr_dv got %0d exp 0", dv_cnt - dv0); end
    n_checks++; if (P_DATA !== 8'hC3) begin n_fail++; $display("FAIL perr_pdata got %h exp c3", P_DATA); end
  endtask

  task automatic test_glitch;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(12);
    n_checks++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d exp 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)); end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL glitch_recover_count got %0d exp 1", dv_cnt - dv0); end
    n_checks++; if (dv_cyc - t0 !== 80) begin n_fail++; $display("FAIL glitch_recover_timing got %0d exp 80", dv_cyc - t0); end
    n_checks++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL glitch_recover_pdata got %h exp 5a", P_DATA); end
  endtask

  task automatic test_stop_error;
    int dv0, se0;
    dv0 = dv_cnt; se0 = se_cnt;
    prescale = 6'd8; par_en = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 8);
    idle(12);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL serr_count got %0d exp 1", se_cnt - se0); end
    n_checks++; if (se_cyc - t0 !== 80) begin n_fail++; $display("FAIL serr_timing got %0d exp 80", se_cyc - t0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL serr_dv got %0d exp 0", dv_cnt - dv0); end
    n_checks++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL serr_pdata got %h exp 5a", P_DATA); end
  endtask

  // Illegal ratio 12 must behave as 8.
  task automatic test_bad_prescale;
    int dv0;
    dv0 = dv_cnt;
    prescale = 6'd12; par_en = 1'b0;
    send_frame(8'h3E, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL badpre_count got %0d exp 1", dv_cnt - dv0); end
    n_checks++; if (dv_cyc - t0 !== 80) begin n_fail++; $display("FAIL badpre_timing got %0d exp 80", dv_cyc - t0); end
    n_checks++; if (P_DATA !== 8'h3E) begin n_fail++; $display("FAIL badpre_pdata got %h exp 3e", P_DATA); end
  endtask

  task automatic test_reset_mid_and_back_to_back;
    int dv0, pe0, se0, t_first;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    prescale = 6'd8; par_en = 1'b0;
    RX_IN = 1'b0;
    idle(8);
    RX_IN = 1'b1;
    idle(8);
    RX_IN = 1'b0;
    idle(5);
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_pdata got %h exp 00", P_DATA); end
    n_checks++; if ({data_valid, par_err, stp_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_pulses got %b exp 000", {data_valid, par_err, stp_err}); end
    RX_IN = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(100);
    n_checks++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin n_fail++; $display("FAIL rstmid_no_pulse got %0d exp 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)); end
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8);
    t_first = t0;
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    n_checks++; if (dv_cnt - dv0 !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", dv_cnt - dv0); end
    n_checks++; if (dv_cyc_prev - t_first !== 80) begin n_fail++; $display("FAIL b2b_first_timing got %0d exp 80", dv_cyc_prev - t_first); end
    n_checks++; if (dv_cyc - dv_cyc_prev !== 80) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 80", dv_cyc - dv_cyc_prev); end
    n_checks++; if (dv_data_prev !== 8'h55) begin n_fail++; $display("FAIL b2b_first_data got %h exp 55", dv_data_prev); end
    n_checks++; if (dv_data !== 8'hAA) begin n_fail++; $display("FAIL b2b_second_data got %h exp aa", dv_data); end
  endtask

  initial begin
    rstn = 1'b0;
    RX_IN = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_typ = 1'b0;
    idle(3);
    test_reset();
    rstn = 1'b1;
    idle(3);
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_parity_error();
    test_glitch();
    test_stop_error();
    test_bad_prescale();
    test_reset_mid_and_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
